smb_result_collector: RTL

- Receive end of the sliding-window/systolic-array path: accepts per-channel convolution results, which arrive skewed one cycle per lane, as the window generator skews d1..d9 into the array.
- Deskews the lanes, buffers the aligned words in a small FIFO and presents one output-pixel word per transfer to the output feature-map writer over valid/ready.
- Tags each word with row/column position and flags end of row and end of frame.

---
 rtl/smb_pkg.sv | 17 +
 rtl/smb_sync_fifo.sv | 81 ++++++++
 rtl/smb_result_collector.sv | 137 +++++++++++++
 3 files changed

// File: rtl/smb_pkg.sv
// Shared defaults and state encoding for the systolic-array result collector
// and the window-generator side that reuses its FIFO.
package smb_pkg;

    localparam int M_DEF          = 16;
    localparam int LANES_DEF      = 4;
    localparam int W_DEF          = 480;
    localparam int H_DEF          = 256;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int COORD_W        = 9;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

endpackage

// File: rtl/smb_sync_fifo.sv
// Single-clock FIFO whose read data is a register that always holds the head
// word, so a word written into an empty FIFO is visible on the next cycle.
module smb_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             wr_fire, rd_fire;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign rd_data = rd_data_q;
    assign rd_fire = rd_en && !empty;
    // A read frees the slot the write lands in, so full+read still accepts.
    assign wr_fire = wr_en && (!full || rd_fire);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        rd_data_d = rd_data_q;
        if (wr_fire) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (rd_fire) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (rd_fire) begin
            if (count_q != CNT_ONE) begin
                rd_data_d = mem_q[rd_ptr_d];
            end else if (wr_fire) begin
                rd_data_d = wr_data;
            end
        end else if (empty && wr_fire) begin
            rd_data_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rd_data_q <= rd_data_d;
        end
    end

endmodule

// File: rtl/smb_result_collector.sv
// Deskews per-channel systolic-array results, buffers aligned words and hands
// them to the feature-map writer tagged with row/column and end-of-frame.
module smb_result_collector
    import smb_pkg::*;
#(
    parameter int M          = M_DEF,
    parameter int LANES      = LANES_DEF,
    parameter int W          = W_DEF,
    parameter int H          = H_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                 clk,
    input  logic                 Rst,
    input  logic [LANES*M-1:0]   res_in,
    input  logic                 res_valid,
    output logic [LANES*M-1:0]   out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [COORD_W-1:0]   out_col,
    output logic [COORD_W-1:0]   out_row,
    output logic                 out_last_col,
    output logic                 frame_end,
    output logic                 overflow,
    output logic                 busy
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(W - 1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(H - 1);

    logic [LANES*M-1:0] aligned_data;
    logic               aligned_vld;
    logic [LANES-2:0]   vld_q, vld_d;
    logic               fifo_full, fifo_empty, xfer;

    // Lane k is delayed LANES-1-k cycles so every lane meets the last one.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        if (k < LANES - 1) begin : g_dly
            localparam int D = LANES - 1 - k;
            logic [M-1:0] dly_q [D];
            logic [M-1:0] dly_d [D];
            always_comb begin
                dly_d[0] = res_in[k*M +: M];
                for (int i = 1; i < D; i++) dly_d[i] = dly_q[i-1];
            end
            always_ff @(posedge clk) dly_q <= dly_d;
            assign aligned_data[k*M +: M] = dly_q[D-1];
        end else begin : g_pass
            assign aligned_data[k*M +: M] = res_in[k*M +: M];
        end
    end

    always_comb begin
        vld_d    = vld_q;
        vld_d[0] = res_valid;
        for (int i = 1; i < LANES - 1; i++) vld_d[i] = vld_q[i-1];
    end
    assign aligned_vld = vld_q[LANES-2];

    smb_sync_fifo #(
        .WIDTH(LANES * M),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (Rst),
        .wr_en  (aligned_vld),
        .wr_data(aligned_data),
        .rd_en  (out_ready),
        .rd_data(out_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign xfer      = out_valid && out_ready;

    state_e             state_q, state_d;
    logic [COORD_W-1:0] col_q, col_d, row_q, row_d;
    logic               last_col_q, last_col_d;
    logic               frame_end_q, frame_end_d;
    logic               overflow_q, overflow_d;

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        frame_end_d = 1'b0;
        state_d     = state_q;
        overflow_d  = overflow_q | (aligned_vld & fifo_full & ~xfer);
        if (xfer) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                if (row_q == ROW_LAST) begin
                    row_d       = '0;
                    frame_end_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        last_col_d = (col_d == COL_LAST);
        // A word of the next frame arriving keeps the FSM active.
        if (aligned_vld) begin
            state_d = ACTIVE;
        end else if (frame_end_d) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            vld_q       <= '0;
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            last_col_q  <= 1'b0;
            frame_end_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            last_col_q  <= last_col_d;
            frame_end_q <= frame_end_d;
            overflow_q  <= overflow_d;
        end
    end

    assign out_col      = col_q;
    assign out_row      = row_q;
    assign out_last_col = last_col_q;
    assign frame_end    = frame_end_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == ACTIVE) || !fifo_empty;

endmodule
